// File: rtl/rand_seq_pkg.sv
// Shared constants and types for the random-sequence counter checker.
// SEQ is the counter's code order after clear; index wraps mod SEQ_LEN.
package rand_seq_pkg;

   localparam int SEQ_LEN = 8;

   typedef enum logic [1:0] {
      HUNT,
      VERIFY,
      LOCKED
   } state_t;

   localparam logic [3:0] SEQ [0:SEQ_LEN-1] = '{
      4'b0000, 4'b0100, 4'b0111, 4'b1000,
      4'b1010, 4'b1101, 4'b1001, 4'b1111
   };

endpackage

// File: rtl/rand_seq_lut.sv
// Code-to-position lookup for the random-sequence counter.
// Codes outside the sequence report legal=0 and pos=0.
module rand_seq_lut
   import rand_seq_pkg::*;
(
   input  logic [3:0] code,
   output logic [2:0] pos,
   output logic       legal
);

   always_comb begin
      pos   = 3'd0;
      legal = 1'b1;
      unique case (code)
         4'b0000: pos = 3'd0;
         4'b0100: pos = 3'd1;
         4'b0111: pos = 3'd2;
         4'b1000: pos = 3'd3;
         4'b1010: pos = 3'd4;
         4'b1101: pos = 3'd5;
         4'b1001: pos = 3'd6;
         4'b1111: pos = 3'd7;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/rand_seq_checker.sv
// Receive-side checker: acquires the counter sequence, locks, flywheels
// through mismatches and keeps a saturating error count.
module rand_seq_checker
   import rand_seq_pkg::*;
#(
   parameter int LOCK_N = 3,
   parameter int LOSS_N = 2,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             sample_valid,
   input  logic [3:0]       code,
   output logic             locked,
   output logic [2:0]       index,
   output logic [3:0]       expected,
   output logic             error,
   output logic             illegal,
   output logic [ERR_W-1:0] err_count
);

   state_t     state;
   logic [2:0] good_cnt;
   logic [2:0] miss_cnt;
   logic [2:0] pos;
   logic       legal;
   logic       hit;
   logic [2:0] idx_p1;
   logic [2:0] idx_p2;
   logic [2:0] pos_p1;
   logic [2:0] good_nx;
   logic [2:0] miss_nx;

   rand_seq_lut u_lut (
      .code  (code),
      .pos   (pos),
      .legal (legal)
   );

   assign hit     = (code == expected);
   assign idx_p1  = index + 3'd1;
   assign idx_p2  = index + 3'd2;
   assign pos_p1  = pos + 3'd1;
   assign good_nx = good_cnt + 3'd1;
   assign miss_nx = miss_cnt + 3'd1;

   always_ff @(posedge clk) begin
      if (clear) begin
         state     <= HUNT;
         locked    <= 1'b0;
         index     <= 3'd0;
         expected  <= 4'd0;
         error     <= 1'b0;
         illegal   <= 1'b0;
         err_count <= '0;
         good_cnt  <= 3'd0;
         miss_cnt  <= 3'd0;
      end else begin
         error   <= 1'b0;
         illegal <= 1'b0;
         if (sample_valid) begin
            unique case (state)
               HUNT: begin
                  if (legal) begin
                     index    <= pos;
                     expected <= SEQ[pos_p1];
                     good_cnt <= 3'd1;
                     miss_cnt <= 3'd0;
                     if (LOCK_N == 1) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end else begin
                        state  <= VERIFY;
                     end
                  end else begin
                     illegal <= 1'b1;
                  end
               end
               VERIFY: begin
                  if (hit) begin
                     index    <= idx_p1;
                     expected <= SEQ[idx_p2];
                     good_cnt <= good_nx;
                     if (good_nx == 3'(LOCK_N)) begin
                        state    <= LOCKED;
                        locked   <= 1'b1;
                        miss_cnt <= 3'd0;
                     end
                  end else if (legal) begin
                     index    <= pos;
                     expected <= SEQ[pos_p1];
                     good_cnt <= 3'd1;
                  end else begin
                     state    <= HUNT;
                     index    <= 3'd0;
                     expected <= 4'd0;
                     good_cnt <= 3'd0;
                     illegal  <= 1'b1;
                  end
               end
               LOCKED: begin
                  illegal <= !legal;
                  if (hit) begin
                     index    <= idx_p1;
                     expected <= SEQ[idx_p2];
                     miss_cnt <= 3'd0;
                  end else begin
                     error <= 1'b1;
                     if (err_count != '1)
                        err_count <= err_count + ERR_W'(1);
                     // Flywheel unless this miss exhausts the loss budget
                     if (miss_nx == 3'(LOSS_N)) begin
                        state    <= HUNT;
                        locked   <= 1'b0;
                        index    <= 3'd0;
                        expected <= 4'd0;
                        miss_cnt <= 3'd0;
                        good_cnt <= 3'd0;
                     end else begin
                        index    <= idx_p1;
                        expected <= SEQ[idx_p2];
                        miss_cnt <= miss_nx;
                     end
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rand_seq_checker.sv
// Scoreboard bench for rand_seq_checker: default build plus a
// small-counter, slow-loss build driven by the same stream.
module tb_rand_seq_checker;

   localparam logic [3:0] SEQ_TB [8] = '{
      4'h0, 4'h4, 4'h7, 4'h8, 4'hA, 4'hD, 4'h9, 4'hF
   };

   typedef struct {
      int   st;
      int   idx;
      int   good;
      int   miss;
      int   err;
      int   lock_n;
      int   loss_n;
      int   err_max;
      logic error;
      logic illegal;
   } mdl_t;

   typedef struct packed {
      logic       locked;
      logic [2:0] index;
      logic [3:0] expected;
      logic       error;
      logic       illegal;
      logic [7:0] err;
   } obs_t;

   typedef struct packed {
      obs_t a;
      obs_t b;
   } exp_t;

   logic       clk = 1'b0;
   logic       clear = 1'b1;
   logic       sample_valid = 1'b0;
   logic [3:0] code = 4'd0;

   logic       a_locked, a_error, a_illegal;
   logic [2:0] a_index;
   logic [3:0] a_expected;
   logic [7:0] a_err;
   logic       b_locked, b_error, b_illegal;
   logic [2:0] b_index;
   logic [3:0] b_expected;
   logic [1:0] b_err;

   int   n_chk = 0;
   int   n_pass = 0;
   mdl_t ma;
   mdl_t mb;
   exp_t sb[$];

   always #5 clk = ~clk;

   rand_seq_checker dut_a (
      .clk          (clk),
      .clear        (clear),
      .sample_valid (sample_valid),
      .code         (code),
      .locked       (a_locked),
      .index        (a_index),
      .expected     (a_expected),
      .error        (a_error),
      .illegal      (a_illegal),
      .err_count    (a_err)
   );

   rand_seq_checker #(.ERR_W(2), .LOSS_N(7)) dut_b (
      .clk          (clk),
      .clear        (clear),
      .sample_valid (sample_valid),
      .code         (code),
      .locked       (b_locked),
      .index        (b_index),
      .expected     (b_expected),
      .error        (b_error),
      .illegal      (b_illegal),
      .err_count    (b_err)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic int seq_pos(logic [3:0] c);
      for (int i = 0; i < 8; i++)
         if (SEQ_TB[i] == c) return i;
      return -1;
   endfunction

   function automatic logic [3:0] exp_of(mdl_t m);
      if (m.st == 0) return 4'd0;
      return SEQ_TB[(m.idx + 1) % 8];
   endfunction

   function automatic obs_t obs(mdl_t m);
      obs_t o;
      o.locked   = (m.st == 2);
      o.index    = 3'(m.idx);
      o.expected = exp_of(m);
      o.error    = m.error;
      o.illegal  = m.illegal;
      o.err      = 8'(m.err);
      return o;
   endfunction

   // st: 0 hunt, 1 verify, 2 locked
   function automatic mdl_t mstep(mdl_t m, logic clr, logic v,
                                  logic [3:0] c);
      int p;
      logic [3:0] e;
      m.error = 1'b0;
      m.illegal = 1'b0;
      if (clr) begin
         m.st = 0; m.idx = 0; m.good = 0; m.miss = 0; m.err = 0;
         return m;
      end
      if (!v) return m;
      p = seq_pos(c);
      e = exp_of(m);
      if (m.st == 0) begin
         if (p < 0) m.illegal = 1'b1;
         else begin
            m.idx = p; m.good = 1; m.miss = 0;
            m.st = (m.lock_n == 1) ? 2 : 1;
         end
      end else if (m.st == 1) begin
         if (c == e) begin
            m.idx = (m.idx + 1) % 8;
            m.good++;
            if (m.good == m.lock_n) begin m.st = 2; m.miss = 0; end
         end else if (p >= 0) begin
            m.idx = p; m.good = 1;
         end else begin
            m.st = 0; m.idx = 0; m.good = 0; m.illegal = 1'b1;
         end
      end else begin
         if (c == e) begin
            m.idx = (m.idx + 1) % 8; m.miss = 0;
         end else begin
            m.error = 1'b1;
            if (p < 0) m.illegal = 1'b1;
            if (m.err < m.err_max) m.err++;
            m.idx = (m.idx + 1) % 8;
            m.miss++;
            if (m.miss == m.loss_n) begin
               m.st = 0; m.idx = 0; m.miss = 0; m.good = 0;
            end
         end
      end
      return m;
   endfunction

   task automatic step(input logic clr, input logic v, input logic [3:0] c);
      exp_t x;
      clear = clr;
      sample_valid = v;
      code = c;
      ma = mstep(ma, clr, v, c);
      mb = mstep(mb, clr, v, c);
      sb.push_back('{a: obs(ma), b: obs(mb)});
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk("a.locked", a_locked, x.a.locked);
      chk("a.index", a_index, x.a.index);
      chk("a.expected", a_expected, x.a.expected);
      chk("a.error", a_error, x.a.error);
      chk("a.illegal", a_illegal, x.a.illegal);
      chk("a.err_count", a_err, x.a.err);
      chk("b.locked", b_locked, x.b.locked);
      chk("b.index", b_index, x.b.index);
      chk("b.expected", b_expected, x.b.expected);
      chk("b.error", b_error, x.b.error);
      chk("b.illegal", b_illegal, x.b.illegal);
      chk("b.err_count", b_err, x.b.err);
   endtask

   initial begin
      int n;
      ma = '{st: 0, idx: 0, good: 0, miss: 0, err: 0,
             lock_n: 3, loss_n: 2, err_max: 255,
             error: 1'b0, illegal: 1'b0};
      mb = ma;
      mb.loss_n = 7;
      mb.err_max = 3;

      step(1'b1, 1'b0, 4'h0);
      step(1'b1, 1'b1, 4'h4);
      chk("rst.locked", a_locked, 0);
      chk("rst.expected", a_expected, 0);

      step(1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b1, 4'h4);
      step(1'b0, 1'b1, 4'h7);
      chk("acq.locked", a_locked, 1);
      chk("acq.index", a_index, 2);
      chk("acq.expected", a_expected, 4'h8);
      chk("acq.err_count", a_err, 0);

      step(1'b0, 1'b1, 4'h5);
      chk("fly.error", a_error, 1);
      chk("fly.illegal", a_illegal, 1);
      chk("fly.err_count", a_err, 1);
      chk("fly.index", a_index, 3);
      chk("fly.locked", a_locked, 1);
      step(1'b0, 1'b1, 4'hA);
      chk("fly.ok1", a_error, 0);
      step(1'b0, 1'b1, 4'hD);
      chk("fly.ok2", a_error, 0);

      step(1'b0, 1'b1, 4'h0);
      chk("loss.err1", a_error, 1);
      step(1'b0, 1'b1, 4'h0);
      chk("loss.err2", a_error, 1);
      chk("loss.locked", a_locked, 0);
      chk("loss.expected", a_expected, 0);
      chk("loss.err_count", a_err, 3);
      step(1'b0, 1'b1, 4'h8);
      step(1'b0, 1'b1, 4'hA);
      step(1'b0, 1'b1, 4'hD);
      chk("relock.locked", a_locked, 1);
      chk("relock.index", a_index, 5);

      n = 0;
      while (n < 20) begin
         if ($urandom_range(0, 3) == 0) begin
            step(1'b0, 1'b0, 4'($urandom));
         end else begin
            step(1'b0, 1'b1, obs(ma).expected);
            n++;
         end
         chk("wrap.error", a_error, 0);
      end
      chk("wrap.locked", a_locked, 1);

      step(1'b1, 1'b0, 4'h0);
      step(1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b1, 4'h4);
      step(1'b0, 1'b1, 4'h7);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'h1);
      chk("sat.b_err", b_err, 3);
      chk("sat.b_locked", b_locked, 1);

      step(1'b1, 1'b1, obs(mb).expected);
      chk("clr.b_locked", b_locked, 0);
      chk("clr.b_index", b_index, 0);
      chk("clr.b_expected", b_expected, 0);
      chk("clr.b_err", b_err, 0);
      chk("clr.a_err", a_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rand_seq_checker.md
Name: rand_seq_checker

Overview:
- Receive-side checker for the team's 4-bit random-sequence synchronous counter.
- The counter's sequence after clear is 0000 -> 0100 -> 0111 -> 1000 -> 1010 -> 1101 -> 1001 -> 1111 -> 0000, with period 8.
- The block samples a 4-bit code stream, acquires and locks to the sequence position, then flywheels. It flags out-of-sequence codes, flags illegal codes and counts errors.
- It sits downstream of a generator, or across a link from one, as a built-in self-test monitor.

Parameters:
- LOCK_N, 3, number of consecutive in-sequence samples (including the first) needed to declare lock; legal range 1..7.
- LOSS_N, 2, number of consecutive mismatching samples while locked that drop lock; legal range 1..7.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- clear  input  1  synchronous, active-high reset.
- sample_valid  input  1  code is sampled on this cycle.
- code  input  4  observed counter value.
- locked  output  1  checker is in LOCKED state.
- index  output  3  sequence position of the last accepted sample (0..7).
- expected  output  4  code expected at the next valid sample.
- error  output  1  one-cycle pulse: mismatch while locked.
- illegal  output  1  one-cycle pulse: sampled code not in the 8-entry set (0001, 0010, 0011, 0101, 0110, 1011, 1100, 1110), in any state.
- err_count  output  ERR_W  saturating count of error pulses.

Behaviour:
- Reset: clear=1 at a rising edge gives state=HUNT, and every output 0: locked=0, index=0, expected=0000, error=0, illegal=0, err_count=0. Internal good_cnt=0, miss_cnt=0. clear overrides sample_valid on the same edge; clear mid-lock behaves identically.
- Outputs are registered. Pulses and state changes appear the cycle after the sampled edge (latency 1).
- sample_valid=0: all state held; error and illegal are 0.
- expected is SEQ[(index+1) mod 8] in VERIFY and LOCKED; it is 0000 in HUNT. index wraps 7 -> 0, so 1111 -> 0000 is a match.
- HUNT:
  - Legal code: index=pos(code), good_cnt=1. Go to LOCKED if LOCK_N=1, else go to VERIFY.
  - Illegal code: stay in HUNT and pulse illegal.
- VERIFY:
  - code==expected: index++, good_cnt++. When good_cnt reaches LOCK_N, go to LOCKED and set miss_cnt=0.
  - Mismatch with a legal code: restart at the new position (index=pos(code), good_cnt=1) and stay in VERIFY.
  - Mismatch with an illegal code: go to HUNT and pulse illegal.
  - No error pulses and no err_count change in VERIFY.
- LOCKED:
  - code==expected: index++, miss_cnt=0.
  - Mismatch: pulse error, increment err_count (saturating at all-ones), index++ (flywheel), miss_cnt++. Illegal codes also pulse illegal.
  - When miss_cnt reaches LOSS_N: go to HUNT, locked=0, index=0, expected=0000, miss_cnt=0. err_count is kept.
- err_count clears only on clear.

Decomposition:
- Package rand_seq_pkg holds:
  - constant SEQ[0:7] = {0000, 0100, 0111, 1000, 1010, 1101, 1001, 1111};
  - state enum {HUNT, VERIFY, LOCKED};
  - SEQ_LEN=8.
- Sub-module rand_seq_lut: combinational, code[3:0] -> pos[2:0] plus legal. The top-level holds the FSM and counters.

Test Plan:
- Acquire: clear, then valid samples 0000, 0100, 0111 -> locked=1 the cycle after 0111; index=2; expected=1000; err_count=0.
- Flywheel: after the acquire above, send 0101 -> error=1, illegal=1, err_count=1, index=3, locked stays 1. Then send 1010 -> no pulse and miss_cnt resets. Then send 1101 -> no pulse.
- Lock loss: while locked, send two consecutive wrong legal codes -> two error pulses, err_count +2, locked=0, expected=0000 on the cycle after the second. Then 1000, 1010, 1101 -> re-lock with index=5.
- Wrap and gaps: run 20 locked samples through 1111 -> 0000, with sample_valid low on random cycles -> no error or illegal; outputs hold during the gaps.
- Saturation and reset: with ERR_W=2 and LOSS_N=7, inject 5 mismatches while locked -> err_count stays 3. Then assert clear mid-stream with sample_valid=1 -> all outputs 0 and state HUNT.
